// File: rtl/riscv_pkg.sv
// Shared definitions for the memory port arbiter: state/owner encodings,
// default bus widths, the grant record and the priority decision.
package riscv_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    // Arbiter state encoding
    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_RESP = 1'b1;

    // Owner of the access currently in flight
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef struct packed {
        logic cpu;
        logic dbg;
    } arb_grant_t;

    // CPU has fixed priority unless DBG has waited long enough to force its turn.
    function automatic arb_grant_t arb_pick(input logic req_cpu,
                                            input logic req_dbg,
                                            input logic dbg_starved);
        arb_grant_t g;
        g.cpu = req_cpu && !(req_dbg && dbg_starved);
        g.dbg = req_dbg && !g.cpu;
        return g;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter for the low-priority requester. Counts cycles spent
// requesting without a grant; at_limit flags that the wait budget is used up.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count;

    // Clear has priority over increment; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + W'(1);
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single-port synchronous-read memory.
// CPU has fixed priority; DBG is guaranteed a slot after STARVE_LIMIT waits.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ARB_IDLE | arbitrate; a granted read moves to ARB_RESP, writes stay here
//   ARB_RESP | memory returns read data to the owner; no grant; back to IDLE
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    logic       state;
    logic       state_nxt;
    logic       owner;
    logic       owner_nxt;
    logic       in_idle;
    logic       in_resp;
    logic       dbg_starved;
    arb_grant_t win;

    // Outputs are forced quiet while reset is high, including a pending response.
    assign in_idle = !reset && (state == ARB_IDLE);
    assign in_resp = !reset && (state == ARB_RESP);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (dbg_req && !dbg_gnt),
        .clr      (!dbg_req || dbg_gnt),
        .at_limit (dbg_starved)
    );

    // Grant decision, only ever made in IDLE.
    always_comb begin
        win = '0;
        if (in_idle) begin
            win = arb_pick(cpu_req, dbg_req, dbg_starved);
        end
    end

    assign cpu_gnt = win.cpu;
    assign dbg_gnt = win.dbg;

    // Route the winner onto the memory port; idle port drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win.cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (win.dbg) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Next state/owner: a granted read waits one cycle for memory data.
    always_comb begin
        state_nxt = ARB_IDLE;
        owner_nxt = owner;
        if (state == ARB_IDLE) begin
            if (win.cpu) begin
                owner_nxt = OWN_CPU;
            end else if (win.dbg) begin
                owner_nxt = OWN_DBG;
            end
            if (mem_en && !mem_we) begin
                state_nxt = ARB_RESP;
            end
        end
    end

    // State and owner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= OWN_CPU;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Response demux: only the owner sees data, everything else reads as zero.
    always_comb begin
        cpu_rvalid = in_resp && (owner == OWN_CPU);
        dbg_rvalid = in_resp && (owner == OWN_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

    assign busy = in_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic        own;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic cpu_req, cpu_we, dbg_req, dbg_we;
        logic e_cpu_gnt, e_dbg_gnt, e_mem_en, e_mem_we;
    } vec_t;
    vec_t vecs [8];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 1'b0; cpu_we = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    // Scoreboard monitor: checks responses, invariants, and records new accesses.
    always @(negedge clk) begin
        rd_exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (reset) begin
                check("rvalid_abandon", 32'({cpu_rvalid, dbg_rvalid}), 32'h0);
            end else if (e.own == OWN_CPU) begin
                check("cpu_rvalid", 32'(cpu_rvalid), 32'h1);
                check("cpu_rdata", cpu_rdata, e.data);
                check("dbg_rvalid_nonowner", 32'(dbg_rvalid), 32'h0);
            end else begin
                check("dbg_rvalid", 32'(dbg_rvalid), 32'h1);
                check("dbg_rdata", dbg_rdata, e.data);
                check("cpu_rvalid_nonowner", 32'(cpu_rvalid), 32'h0);
            end
        end else begin
            check("no_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'h0);
        end
        check("rdata_zero", (cpu_rvalid ? 32'h0 : cpu_rdata) | (dbg_rvalid ? 32'h0 : dbg_rdata), 32'h0);
        check("gnt_onehot", 32'(cpu_gnt && dbg_gnt), 32'h0);
        check("we_without_en", 32'(mem_we && !mem_en), 32'h0);
        if (!reset) begin
            if (cpu_gnt) begin
                if (!cpu_we) sb.push_back('{OWN_CPU, ref_mem[cpu_addr[9:2]]});
                else         ref_mem[cpu_addr[9:2]] = cpu_wdata;
            end
            if (dbg_gnt) begin
                if (!dbg_we) sb.push_back('{OWN_DBG, ref_mem[dbg_addr[9:2]]});
                else         ref_mem[dbg_addr[9:2]] = dbg_wdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_dbg;
        logic [31:0] exp_addr;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

        //                 creq cwe dreq dwe | cgnt dgnt en we
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held two cycles with both masters requesting
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hB;
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt_en", 32'({cpu_gnt, dbg_gnt, mem_en, mem_we}), 32'h0);
            check("rst_rvalid_busy", 32'({cpu_rvalid, dbg_rvalid, busy}), 32'h0);
            check("rst_rdata", cpu_rdata | dbg_rdata, 32'h0);
            check("rst_mem_bus", mem_addr | mem_wdata, 32'h0);
            step();
        end
        reset = 1'b0;
        @(negedge clk);
        check("first_gnt_cpu", 32'(cpu_gnt), 32'h1);
        check("first_gnt_dbg", 32'(dbg_gnt), 32'h0);
        check("first_addr", mem_addr, 32'h40);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("post_rst_dbg_gnt", 32'(dbg_gnt), 32'h1);
        step();
        idle_all();
        step();

        // Table-driven single-cycle arbitration vectors
        cpu_addr = 32'h30; cpu_wdata = 32'h3;
        dbg_addr = 32'h34; dbg_wdata = 32'h4;
        for (int v = 0; v < 8; v++) begin
            cpu_req = vecs[v].cpu_req; cpu_we = vecs[v].cpu_we;
            dbg_req = vecs[v].dbg_req; dbg_we = vecs[v].dbg_we;
            exp_addr = vecs[v].e_cpu_gnt ? 32'h30 : (vecs[v].e_dbg_gnt ? 32'h34 : 32'h0);
            @(negedge clk);
            check("vec_cpu_gnt", 32'(cpu_gnt), 32'(vecs[v].e_cpu_gnt));
            check("vec_dbg_gnt", 32'(dbg_gnt), 32'(vecs[v].e_dbg_gnt));
            check("vec_mem_en", 32'(mem_en), 32'(vecs[v].e_mem_en));
            check("vec_mem_we", 32'(mem_we), 32'(vecs[v].e_mem_we));
            check("vec_mem_addr", mem_addr, exp_addr);
            step();
            idle_all();
            step();
        end

        // CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        check("rd_cpu_gnt", 32'({cpu_gnt, mem_en, mem_we}), 32'b110);
        check("rd_mem_addr", mem_addr, 32'h10);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_busy", 32'(busy), 32'h1);
        check("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_no_gnt_in_resp", 32'({cpu_gnt, dbg_gnt, mem_en}), 32'h0);
        step();

        // Simultaneous CPU read 0x0 and DBG write 0x20
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h55;
        @(negedge clk);
        check("mix_t0_gnt", 32'({cpu_gnt, dbg_gnt}), 32'b10);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("mix_t1_busy_gnt", 32'({busy, dbg_gnt}), 32'b10);
        step();
        @(negedge clk);
        check("mix_t2_gnt", 32'({cpu_gnt, dbg_gnt, mem_we}), 32'b011);
        check("mix_t2_addr", mem_addr, 32'h20);
        step();
        idle_all();
        check("mix_mem8", mem[8], 32'h55);
        step();

        // Starvation: CPU writes every cycle, DBG waits from cycle 0
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'h77;
        for (int c = 0; c < 6; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = 32'h80 + 32'(c) * 32'd4; cpu_wdata = 32'(c);
            @(negedge clk);
            check("starve_cpu_gnt", 32'(cpu_gnt), 32'(c != 4));
            check("starve_dbg_gnt", 32'(dbg_gnt), 32'(c == 4));
            if (c == 5) check("starve_cnt_clear", 32'(dut.u_starve.count), 32'h0);
            got_dbg = dbg_gnt;
            step();
            if (got_dbg) dbg_req = 1'b0;
        end
        idle_all();
        check("starve_mem_dbg", mem[64], 32'h77);
        step();

        // Reset during RESP abandons the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        check("abort_gnt", 32'(cpu_gnt), 32'h1);
        step();
        cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_rvalid_t1", 32'(cpu_rvalid), 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_rvalid_t2", 32'(cpu_rvalid), 32'h0);
        check("abort_state_idle", 32'(dut.state), 32'(ARB_IDLE));
        check("abort_busy", 32'(busy), 32'h0);
        step();

        // DBG back-to-back writes 0x0..0xC, then read back
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1;
            dbg_addr = 32'(i) * 32'd4; dbg_wdata = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("b2b_dbg_gnt", 32'(dbg_gnt), 32'h1);
            step();
        end
        idle_all();
        for (int i = 0; i < 4; i++) begin
            check("b2b_mem", mem[i], 32'hC0DE0000 + 32'(i));
        end
        step();
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'(i) * 32'd4;
            @(negedge clk);
            check("rb_dbg_gnt", 32'(dbg_gnt), 32'h1);
            step();
            dbg_req = 1'b0;
            @(negedge clk);
            check("rb_dbg_rdata", dbg_rdata, 32'hC0DE0000 + 32'(i));
            step();
        end

        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
